// File: rtl/rob_pkg.sv
// Shared definitions for the multi-commit reorder buffer.
//   - rob_type_e : instruction class encodings carried per entry
//   - st_state_e : store-commit handshake states
//   - is_store() : true for SB/SH/SW
//   - tag_width(): tag width needed to address a given number of entries
package rob_pkg;

   typedef enum logic [2:0] {
      TY_SB     = 3'd0,
      TY_SH     = 3'd1,
      TY_SW     = 3'd2,
      TY_REG    = 3'd3,
      TY_JALR   = 3'd4,
      TY_BRANCH = 3'd5,
      TY_EXIT   = 3'd6
   } rob_type_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } st_state_e;

   function automatic logic is_store(input logic [2:0] t);
      return (t == TY_SB) || (t == TY_SH) || (t == TY_SW);
   endfunction

   function automatic int tag_width(input int entries);
      return (entries <= 2) ? 1 : $clog2(entries);
   endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Combinational retire-group selector.
// Looks at the first COMMIT_WIDTH entries starting at head and decides how
// many retire this cycle, and whether the slot-0 entry mispredicted.
//   en_i         : retirement allowed this cycle (no flush, store path idle)
//   count_i      : occupied entries
//   done_i       : done bits, slot k = head+k
//   type_i       : 3-bit types, slot k in bits [3k+2:3k]
//   value0_i     : slot-0 result (JALR target / branch outcome in bit 0)
//   target0_i    : slot-0 predicted/taken target
//   pred0_i      : slot-0 branch prediction
//   ret_cnt_o    : number of entries retiring through the register path
//   mispredict_o : slot 0 retires and mispredicted
module rob_commit_sel
   import rob_pkg::*;
#(
   parameter int COMMIT_WIDTH = 2,
   parameter int DEPTH_LOG2   = 5,
   parameter int XLEN         = 32
) (
   input  logic                      en_i,
   input  logic [DEPTH_LOG2:0]       count_i,
   input  logic [COMMIT_WIDTH-1:0]   done_i,
   input  logic [3*COMMIT_WIDTH-1:0] type_i,
   input  logic [XLEN-1:0]           value0_i,
   input  logic [XLEN-1:0]           target0_i,
   input  logic                      pred0_i,
   output logic [DEPTH_LOG2:0]       ret_cnt_o,
   output logic                      mispredict_o
);

   localparam int CNT_W = DEPTH_LOG2 + 1;

   logic       stop;
   logic [2:0] ty0;

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      ret_cnt_o = '0;
      stop      = 1'b0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         if (!stop) begin
            if (!en_i || (count_i <= CNT_W'(k)) || !done_i[k]) begin
               stop = 1'b1;
            end else if (type_i[3*k +: 3] == TY_REG) begin
               ret_cnt_o = CNT_W'(k + 1);
            end else begin
               // Non-REG entries retire alone at slot 0 and close the group;
               // stores never retire here, they go through the memory handshake.
               if ((k == 0) && !is_store(type_i[3*k +: 3])) ret_cnt_o = CNT_W'(1);
               stop = 1'b1;
            end
         end
      end
   end

   assign ty0          = type_i[2:0];
   assign mispredict_o = (ret_cnt_o != '0) &&
                         (((ty0 == TY_JALR)   && (value0_i != target0_i)) ||
                          ((ty0 == TY_BRANCH) && (value0_i[0] != pred0_i)));

endmodule

// File: rtl/rob_mw.sv
// Multi-commit reorder buffer between dispatch and RF / memory / predictor.
// Ports:
//   clk_in, rst_n_in, rdy_in          : clock, async active-low reset, global enable
//   disp_*                            : dispatch handshake and entry fields; disp_id_out = tail
//   wb_*                              : WB_PORTS result channels (lowest port wins on same tag)
//   st_*                              : store address/data completion
//   qry_*                             : two combinational operand lookups
//   rf_*                              : up to COMMIT_WIDTH registered register commits
//   mem_*                             : registered store commit with valid/ready
//   pred_*                            : branch outcome pulse
//   flush_out, redirect_addr_out      : misprediction redirect pulse
//   halt_out                          : sticky, set when EXIT retires
module rob_mw
   import rob_pkg::*;
#(
   parameter int DEPTH_LOG2   = 5,
   parameter int WB_PORTS     = 3,
   parameter int COMMIT_WIDTH = 2,
   parameter int XLEN         = 32,
   parameter int REG_W        = 5
) (
   input  logic                             clk_in,
   input  logic                             rst_n_in,
   input  logic                             rdy_in,
   input  logic                             disp_valid_in,
   output logic                             disp_ready_out,
   input  logic [2:0]                       disp_type_in,
   input  logic [REG_W-1:0]                 disp_dest_in,
   input  logic [XLEN-1:0]                  disp_value_in,
   input  logic [XLEN-1:0]                  disp_pc_in,
   input  logic [XLEN-1:0]                  disp_target_in,
   input  logic                             disp_pred_taken_in,
   input  logic                             disp_done_in,
   output logic [DEPTH_LOG2-1:0]            disp_id_out,
   input  logic [WB_PORTS-1:0]              wb_valid_in,
   input  logic [WB_PORTS*DEPTH_LOG2-1:0]   wb_id_in,
   input  logic [WB_PORTS*XLEN-1:0]         wb_value_in,
   input  logic                             st_valid_in,
   input  logic [DEPTH_LOG2-1:0]            st_id_in,
   input  logic [XLEN-1:0]                  st_addr_in,
   input  logic [XLEN-1:0]                  st_data_in,
   input  logic [2*DEPTH_LOG2-1:0]          qry_id_in,
   output logic [1:0]                       qry_hit_out,
   output logic [2*XLEN-1:0]                qry_value_out,
   output logic [COMMIT_WIDTH-1:0]          rf_we_out,
   output logic [COMMIT_WIDTH*REG_W-1:0]    rf_rd_out,
   output logic [COMMIT_WIDTH*XLEN-1:0]     rf_value_out,
   output logic [COMMIT_WIDTH*DEPTH_LOG2-1:0] rf_id_out,
   output logic                             mem_valid_out,
   input  logic                             mem_ready_in,
   output logic [1:0]                       mem_type_out,
   output logic [XLEN-1:0]                  mem_addr_out,
   output logic [XLEN-1:0]                  mem_data_out,
   output logic                             pred_valid_out,
   output logic [XLEN-1:0]                  pred_pc_out,
   output logic                             pred_taken_out,
   output logic                             flush_out,
   output logic [XLEN-1:0]                  redirect_addr_out,
   output logic                             halt_out
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int TAG_W = tag_width(DEPTH);
   localparam int CNT_W = DEPTH_LOG2 + 1;

   // Control state
   logic [TAG_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q, count_d, retired, ret_cnt;
   logic [DEPTH-1:0] done_q, occ;
   st_state_e        st_q;

   // Entry payload
   logic [2:0]       type_q   [DEPTH];
   logic [REG_W-1:0] dest_q   [DEPTH];
   logic [XLEN-1:0]  value_q  [DEPTH];
   logic [XLEN-1:0]  addr_q   [DEPTH];
   logic [XLEN-1:0]  pc_q     [DEPTH];
   logic [XLEN-1:0]  target_q [DEPTH];
   logic             pred_q   [DEPTH];

   // Registered outputs
   logic [COMMIT_WIDTH-1:0]          rf_we_q;
   logic [COMMIT_WIDTH*REG_W-1:0]    rf_rd_q;
   logic [COMMIT_WIDTH*XLEN-1:0]     rf_value_q;
   logic [COMMIT_WIDTH*TAG_W-1:0]    rf_id_q;
   logic [1:0]                       mem_type_q;
   logic [XLEN-1:0]                  mem_addr_q, mem_data_q, pred_pc_q, redirect_q;
   logic                             pred_valid_q, pred_taken_q, flush_q, halt_q;

   logic [TAG_W-1:0]          slot_idx [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0]   done_rot;
   logic [3*COMMIT_WIDTH-1:0] type_rot;
   logic                      disp_fire, mispredict, store_issue, store_retire;
   logic [XLEN-1:0]           redirect_d;
   logic [TAG_W-1:0]          qid;
   logic                      found;

   assign disp_ready_out = (count_q != CNT_W'(DEPTH)) && !flush_q;
   assign disp_id_out    = tail_q;
   assign disp_fire      = disp_valid_in && disp_ready_out;

   // Slot i is occupied when its distance from head is below count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         occ[i] = {1'b0, TAG_W'(TAG_W'(i) - head_q)} < count_q;
   end

   always_comb begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         slot_idx[k]          = head_q + TAG_W'(k);
         done_rot[k]          = done_q[slot_idx[k]];
         type_rot[3*k +: 3]   = type_q[slot_idx[k]];
      end
   end

   rob_commit_sel #(
      .COMMIT_WIDTH (COMMIT_WIDTH),
      .DEPTH_LOG2   (DEPTH_LOG2),
      .XLEN         (XLEN)
   ) u_sel (
      .en_i         (!flush_q && (st_q == ST_IDLE)),
      .count_i      (count_q),
      .done_i       (done_rot),
      .type_i       (type_rot),
      .value0_i     (value_q[head_q]),
      .target0_i    (target_q[head_q]),
      .pred0_i      (pred_q[head_q]),
      .ret_cnt_o    (ret_cnt),
      .mispredict_o (mispredict)
   );

   assign store_issue  = (st_q == ST_IDLE) && !flush_q && (count_q != '0) &&
                         done_q[head_q] && is_store(type_q[head_q]);
   assign store_retire = (st_q == ST_ISSUE) && mem_ready_in;
   assign retired      = store_retire ? CNT_W'(1) : ret_cnt;
   assign count_d      = count_q + CNT_W'(disp_fire) - retired;

   // JALR redirects to its computed target; a branch to target if taken, else fall-through.
   assign redirect_d = (type_q[head_q] == TY_JALR) ? value_q[head_q] :
                       value_q[head_q][0] ? target_q[head_q] : pc_q[head_q] + XLEN'(4);

   // Operand lookup: same-cycle dispatch, then lowest write-back port, then stored result.
   always_comb begin
      qry_hit_out   = '0;
      qry_value_out = '0;
      qid           = '0;
      found         = 1'b0;
      for (int q = 0; q < 2; q++) begin
         qid   = qry_id_in[q*TAG_W +: TAG_W];
         found = 1'b0;
         if (disp_fire && disp_done_in && (tail_q == qid)) begin
            found                          = 1'b1;
            qry_hit_out[q]                 = 1'b1;
            qry_value_out[q*XLEN +: XLEN]  = disp_value_in;
         end
         for (int p = 0; p < WB_PORTS; p++) begin
            if (!found && wb_valid_in[p] && (wb_id_in[p*TAG_W +: TAG_W] == qid)) begin
               found                         = 1'b1;
               qry_hit_out[q]                = 1'b1;
               qry_value_out[q*XLEN +: XLEN] = wb_value_in[p*XLEN +: XLEN];
            end
         end
         if (!found && done_q[qid]) begin
            qry_hit_out[q]                = 1'b1;
            qry_value_out[q*XLEN +: XLEN] = value_q[qid];
         end
      end
   end

   // NOTE: entry payload has no reset; an entry is only meaningful while its
   // slot is occupied, and occupancy/done bits are what reset clears.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !flush_q) begin
         // Descending order so the lowest port's write lands last and wins.
         for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid_in[p] && occ[wb_id_in[p*TAG_W +: TAG_W]])
               value_q[wb_id_in[p*TAG_W +: TAG_W]] <= wb_value_in[p*XLEN +: XLEN];
         end
         if (st_valid_in && occ[st_id_in]) begin
            addr_q[st_id_in]  <= st_addr_in;
            value_q[st_id_in] <= st_data_in;
         end
         if (disp_fire) begin
            type_q[tail_q]   <= disp_type_in;
            dest_q[tail_q]   <= disp_dest_in;
            value_q[tail_q]  <= disp_value_in;
            pc_q[tail_q]     <= disp_pc_in;
            target_q[tail_q] <= disp_target_in;
            pred_q[tail_q]   <= disp_pred_taken_in;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         done_q       <= '0;
         st_q         <= ST_IDLE;
         rf_we_q      <= '0;
         rf_rd_q      <= '0;
         rf_value_q   <= '0;
         rf_id_q      <= '0;
         mem_type_q   <= '0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         pred_valid_q <= 1'b0;
         pred_pc_q    <= '0;
         pred_taken_q <= 1'b0;
         flush_q      <= 1'b0;
         redirect_q   <= '0;
         halt_q       <= 1'b0;
      end else if (rdy_in) begin
         if (flush_q) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            done_q       <= '0;
            flush_q      <= 1'b0;
            rf_we_q      <= '0;
            pred_valid_q <= 1'b0;
         end else begin
            head_q  <= head_q + TAG_W'(retired);
            tail_q  <= tail_q + TAG_W'(disp_fire);
            count_q <= count_d;
            for (int p = 0; p < WB_PORTS; p++) begin
               if (wb_valid_in[p] && occ[wb_id_in[p*TAG_W +: TAG_W]])
                  done_q[wb_id_in[p*TAG_W +: TAG_W]] <= 1'b1;
            end
            if (st_valid_in && occ[st_id_in]) done_q[st_id_in] <= 1'b1;
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
               if (CNT_W'(k) < retired) done_q[slot_idx[k]] <= 1'b0;
            end
            if (disp_fire) done_q[tail_q] <= disp_done_in;

            for (int k = 0; k < COMMIT_WIDTH; k++) begin
               rf_we_q[k] <= (CNT_W'(k) < ret_cnt) &&
                             ((type_rot[3*k +: 3] == TY_REG) || (type_rot[3*k +: 3] == TY_JALR));
               rf_rd_q[k*REG_W +: REG_W] <= dest_q[slot_idx[k]];
               rf_value_q[k*XLEN +: XLEN] <= (type_rot[3*k +: 3] == TY_JALR) ?
                                             pc_q[slot_idx[k]] + XLEN'(4) : value_q[slot_idx[k]];
               rf_id_q[k*TAG_W +: TAG_W] <= slot_idx[k];
            end

            pred_valid_q <= (ret_cnt != '0) && (type_rot[2:0] == TY_BRANCH);
            pred_pc_q    <= pc_q[head_q];
            pred_taken_q <= value_q[head_q][0];
            flush_q      <= mispredict;
            if (mispredict) redirect_q <= redirect_d;
            if ((ret_cnt != '0) && (type_rot[2:0] == TY_EXIT)) halt_q <= 1'b1;

            case (st_q)
               ST_IDLE: begin
                  if (store_issue) begin
                     st_q       <= ST_ISSUE;
                     mem_type_q <= type_q[head_q][1:0];
                     mem_addr_q <= addr_q[head_q];
                     mem_data_q <= value_q[head_q];
                  end
               end
               ST_ISSUE: begin
                  if (mem_ready_in) st_q <= ST_IDLE;
               end
               default: st_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign rf_we_out         = rf_we_q;
   assign rf_rd_out         = rf_rd_q;
   assign rf_value_out      = rf_value_q;
   assign rf_id_out         = rf_id_q;
   assign mem_valid_out     = (st_q == ST_ISSUE);
   assign mem_type_out      = mem_type_q;
   assign mem_addr_out      = mem_addr_q;
   assign mem_data_out      = mem_data_q;
   assign pred_valid_out    = pred_valid_q;
   assign pred_pc_out       = pred_pc_q;
   assign pred_taken_out    = pred_taken_q;
   assign flush_out         = flush_q;
   assign redirect_addr_out = redirect_q;
   assign halt_out          = halt_q;

endmodule

// File: tb/tb_rob_mw.sv
// Directed self-checking bench for rob_mw with a commit scoreboard.
module tb_rob_mw;
   import rob_pkg::*;

   localparam int DL  = 5;
   localparam int WBP = 3;
   localparam int CW  = 2;
   localparam int XL  = 32;
   localparam int RW  = 5;
   localparam int TW  = DL;

   logic              clk, rst_n, rdy;
   logic              disp_valid, disp_ready, disp_pred, disp_done;
   logic [2:0]        disp_type;
   logic [RW-1:0]     disp_dest;
   logic [XL-1:0]     disp_value, disp_pc, disp_target;
   logic [TW-1:0]     disp_id;
   logic [WBP-1:0]    wb_valid;
   logic [WBP*TW-1:0] wb_id;
   logic [WBP*XL-1:0] wb_value;
   logic              st_valid;
   logic [TW-1:0]     st_id;
   logic [XL-1:0]     st_addr, st_data;
   logic [2*TW-1:0]   qry_id;
   logic [1:0]        qry_hit;
   logic [2*XL-1:0]   qry_value;
   logic [CW-1:0]     rf_we;
   logic [CW*RW-1:0]  rf_rd;
   logic [CW*XL-1:0]  rf_value;
   logic [CW*TW-1:0]  rf_id;
   logic              mem_valid, mem_ready;
   logic [1:0]        mem_type;
   logic [XL-1:0]     mem_addr, mem_data, pred_pc, redirect_addr;
   logic              pred_valid, pred_taken, flush, halt;

   rob_mw #(.DEPTH_LOG2(DL), .WB_PORTS(WBP), .COMMIT_WIDTH(CW), .XLEN(XL), .REG_W(RW)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
      .disp_valid_in(disp_valid), .disp_ready_out(disp_ready), .disp_type_in(disp_type),
      .disp_dest_in(disp_dest), .disp_value_in(disp_value), .disp_pc_in(disp_pc),
      .disp_target_in(disp_target), .disp_pred_taken_in(disp_pred), .disp_done_in(disp_done),
      .disp_id_out(disp_id),
      .wb_valid_in(wb_valid), .wb_id_in(wb_id), .wb_value_in(wb_value),
      .st_valid_in(st_valid), .st_id_in(st_id), .st_addr_in(st_addr), .st_data_in(st_data),
      .qry_id_in(qry_id), .qry_hit_out(qry_hit), .qry_value_out(qry_value),
      .rf_we_out(rf_we), .rf_rd_out(rf_rd), .rf_value_out(rf_value), .rf_id_out(rf_id),
      .mem_valid_out(mem_valid), .mem_ready_in(mem_ready), .mem_type_out(mem_type),
      .mem_addr_out(mem_addr), .mem_data_out(mem_data),
      .pred_valid_out(pred_valid), .pred_pc_out(pred_pc), .pred_taken_out(pred_taken),
      .flush_out(flush), .redirect_addr_out(redirect_addr), .halt_out(halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] rd;
      logic [XL-1:0] val;
      logic [TW-1:0] id;
   } commit_t;

   commit_t sb_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the edge and any
   // register commit is matched against the head of the scoreboard.
   task automatic cyc();
      commit_t e;
      @(posedge clk);
      #1;
      for (int k = 0; k < CW; k++) begin
         if (rf_we[k]) begin
            check("commit_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("commit_rd",    rf_rd[k*RW +: RW],    e.rd);
               check("commit_value", rf_value[k*XL +: XL], e.val);
               check("commit_id",    rf_id[k*TW +: TW],    e.id);
            end
         end
      end
   endtask

   task automatic disp(input logic [2:0] ty, input logic [RW-1:0] rd, input logic [XL-1:0] val,
                       input logic [XL-1:0] pc, input logic [XL-1:0] tgt, input logic pred,
                       input logic done);
      disp_type = ty; disp_dest = rd; disp_value = val; disp_pc = pc;
      disp_target = tgt; disp_pred = pred; disp_done = done; disp_valid = 1'b1;
      cyc();
      disp_valid = 1'b0;
   endtask

   task automatic push(input logic [RW-1:0] rd, input logic [XL-1:0] val, input logic [TW-1:0] id);
      commit_t e;
      e.rd = rd; e.val = val; e.id = id;
      sb_q.push_back(e);
   endtask

   task automatic wb_set(input int p, input logic [TW-1:0] id, input logic [XL-1:0] v);
      wb_valid[p]          = 1'b1;
      wb_id[p*TW +: TW]    = id;
      wb_value[p*XL +: XL] = v;
   endtask

   task automatic set_qry(input logic [TW-1:0] q0, input logic [TW-1:0] q1);
      qry_id = {q1, q0};
   endtask

   task automatic wait_drain(input int budget, output int cycles);
      cycles = 0;
      while (sb_q.size() != 0 && cycles < budget) begin
         cyc();
         cycles++;
      end
      check("drain_done", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; rdy = 1'b1; mem_ready = 1'b0;
      disp_valid = 1'b0; disp_type = '0; disp_dest = '0; disp_value = '0; disp_pc = '0;
      disp_target = '0; disp_pred = 1'b0; disp_done = 1'b0;
      wb_valid = '0; wb_id = '0; wb_value = '0;
      st_valid = 1'b0; st_id = '0; st_addr = '0; st_data = '0;
      qry_id = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;

      // Reset state
      check("rst_disp_ready", disp_ready, 1'b1);
      check("rst_disp_id",    disp_id, 0);
      check("rst_rf_we",      rf_we, 0);
      check("rst_mem_valid",  mem_valid, 0);
      check("rst_flush",      flush, 0);
      check("rst_halt",       halt, 0);
      check("rst_pred_valid", pred_valid, 0);
      check("rst_qry_hit",    qry_hit, 0);

      // Fill: tag 0 pending, tags 1..31 done; nothing retires behind tag 0
      for (int i = 0; i < 32; i++) begin
         check("fill_disp_id", disp_id, 64'(i));
         check("fill_ready", disp_ready, 1'b1);
         push(RW'(i % 31 + 1), 32'h1000 + 32'(i), TW'(i));
         disp(3'(TY_REG), RW'(i % 31 + 1), (i == 0) ? 32'h0 : 32'h1000 + 32'(i),
              32'(i * 4), 32'h0, 1'b0, (i != 0));
      end
      check("full_ready", disp_ready, 1'b0);
      check("full_disp_id_wrap", disp_id, 0);
      cyc();
      check("full_ready_hold", disp_ready, 1'b0);

      // Complete tag 0; drain two per cycle
      wb_set(1, 5'd0, 32'h1000);
      cyc();
      wb_valid = '0;
      cyc();
      check("drain_first_pair", rf_we, 2'b11);
      check("drain_ready", disp_ready, 1'b1);
      wait_drain(30, n);
      check("drain_cycles", 64'(n), 64'd15);

      // Out-of-order write-back: tags 0,1,2 completed as 2,1,0
      push(5'd5, 32'hA0, 5'd0);
      push(5'd6, 32'hB1, 5'd1);
      push(5'd7, 32'h55, 5'd2);
      disp(3'(TY_REG), 5'd5, 32'h0, 32'h10, 32'h0, 1'b0, 1'b0);
      disp(3'(TY_REG), 5'd6, 32'h0, 32'h14, 32'h0, 1'b0, 1'b0);
      disp(3'(TY_REG), 5'd7, 32'h0, 32'h18, 32'h0, 1'b0, 1'b0);
      wb_set(0, 5'd2, 32'h55);
      set_qry(5'd2, 5'd1);
      #1;
      check("qry_wb_bypass_hit", qry_hit[0], 1'b1);
      check("qry_wb_bypass_val", qry_value[XL-1:0], 32'h55);
      check("qry_pending_miss",  qry_hit[1], 1'b0);
      cyc();
      wb_valid = '0;
      wb_set(0, 5'd1, 32'hB1);
      wb_set(2, 5'd1, 32'hBAD);
      #1;
      check("qry_stored_hit", qry_hit[0], 1'b1);
      check("qry_stored_val", qry_value[XL-1:0], 32'h55);
      cyc();
      wb_valid = '0;
      check("ooo_no_early_commit", rf_we, 0);
      #1;
      check("qry_port0_wins", qry_value[2*XL-1:XL], 32'hB1);
      wb_set(1, 5'd0, 32'hA0);
      cyc();
      wb_valid = '0;
      wait_drain(5, n);
      check("ooo_cycles", 64'(n), 64'd2);

      // JALR predicted correctly: rd gets pc+4, no flush
      push(5'd8, 32'h304, 5'd3);
      disp(3'(TY_JALR), 5'd8, 32'h0, 32'h300, 32'h400, 1'b0, 1'b0);
      wb_set(0, 5'd3, 32'h400);
      cyc();
      wb_valid = '0;
      wait_drain(4, n);
      check("jalr_no_flush", flush, 1'b0);

      // Store stall: SW at head blocks a done REG behind it
      push(5'd9, 32'h99, 5'd5);
      disp(3'(TY_SW), 5'd0, 32'h0, 32'h400, 32'h0, 1'b0, 1'b0);
      disp(3'(TY_REG), 5'd9, 32'h99, 32'h404, 32'h0, 1'b0, 1'b1);
      st_valid = 1'b1; st_id = 5'd4; st_addr = 32'h100; st_data = 32'hAB;
      cyc();
      st_valid = 1'b0;
      cyc();
      check("st_valid_issue", mem_valid, 1'b1);
      check("st_addr", mem_addr, 32'h100);
      check("st_data", mem_data, 32'hAB);
      check("st_type", mem_type, 2'd2);
      for (int i = 0; i < 2; i++) begin
         cyc();
         check("st_valid_held", mem_valid, 1'b1);
         check("st_blocks_reg", rf_we, 0);
      end
      mem_ready = 1'b1;
      cyc();
      mem_ready = 1'b0;
      check("st_valid_fall", mem_valid, 1'b0);
      check("st_retire_no_rf", rf_we, 0);
      wait_drain(3, n);
      check("st_then_reg_cycles", 64'(n), 64'd1);

      // Branch mispredict: pred 0, outcome 1, target 0x200
      disp(3'(TY_BRANCH), 5'd0, 32'h0, 32'h180, 32'h200, 1'b0, 1'b0);
      disp(3'(TY_REG), 5'd10, 32'hEE, 32'h184, 32'h0, 1'b0, 1'b1);
      wb_set(2, 5'd6, 32'h1);
      cyc();
      wb_valid = '0;
      cyc();
      check("br_flush",      flush, 1'b1);
      check("br_redirect",   redirect_addr, 32'h200);
      check("br_pred_valid", pred_valid, 1'b1);
      check("br_pred_pc",    pred_pc, 32'h180);
      check("br_pred_taken", pred_taken, 1'b1);
      check("br_ready_low",  disp_ready, 1'b0);
      check("br_group_ends", rf_we, 0);
      disp(3'(TY_REG), 5'd11, 32'h11, 32'h200, 32'h0, 1'b0, 1'b1);
      check("br_flush_pulse",  flush, 1'b0);
      check("br_pred_pulse",   pred_valid, 1'b0);
      check("br_tail_cleared", disp_id, 0);
      check("br_ready_back",   disp_ready, 1'b1);
      cyc();
      cyc();

      // Dispatch bypass lookup into a fresh buffer, commits from tag 0
      set_qry(5'd31, 5'd0);
      disp_type = 3'(TY_REG); disp_dest = 5'd12; disp_value = 32'h12; disp_pc = 32'h200;
      disp_target = 32'h0; disp_pred = 1'b0; disp_done = 1'b1; disp_valid = 1'b1;
      #1;
      check("qry_disp_hit", qry_hit[1], 1'b1);
      check("qry_disp_val", qry_value[2*XL-1:XL], 32'h12);
      push(5'd12, 32'h12, 5'd0);
      cyc();
      disp_valid = 1'b0;
      wait_drain(3, n);
      check("post_flush_cycles", 64'(n), 64'd1);

      // EXIT sets a sticky halt
      disp(3'(TY_EXIT), 5'd0, 32'h0, 32'h204, 32'h0, 1'b0, 1'b1);
      cyc();
      check("halt_set", halt, 1'b1);
      cyc();
      check("halt_sticky", halt, 1'b1);

      // Reset mid-operation with 10 entries held
      for (int i = 0; i < 10; i++)
         disp(3'(TY_REG), RW'(i + 1), 32'h0, 32'(i * 4), 32'h0, 1'b0, 1'b0);
      check("held_disp_id", disp_id, 12);
      set_qry(5'd2, 5'd3);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_halt",    halt, 1'b0);
      check("mid_rst_disp_id", disp_id, 0);
      check("mid_rst_ready",   disp_ready, 1'b1);
      check("mid_rst_rf_we",   rf_we, 0);
      check("mid_rst_flush",   flush, 0);
      check("mid_rst_qry",     qry_hit, 0);
      @(negedge clk);
      rst_n = 1'b1;
      push(5'd13, 32'h13, 5'd0);
      disp(3'(TY_REG), 5'd13, 32'h13, 32'h0, 32'h0, 1'b0, 1'b1);
      wait_drain(3, n);
      check("post_rst_cycles", 64'(n), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
